hint_bit_unpack_stream: RTL
===========================

// Module: hint_bit_unpack_stream
// PURPOSE
//  Streaming, parametrised ML-DSA HintBitUnpack (FIPS 204 Alg. 21) for the verify path.
//  - Input: OMEGA+K encoded hint bytes over a valid/ready stream.
//  - Output: K hint polynomials of N bits, one per valid/ready beat, plus done/ok status.
//  - Detects every malformed encoding; adds a hint < N check and output backpressure.
// PARAMETERS
//  K      8   polynomials per vector (4/6/8 for ML-DSA-44/65/87)
//  OMEGA  75  max hints and index-byte count (80/55/75)
//  N      256 coefficients per polynomial; must be <= 256
// PORTS
//  clk       in   1        clock, rising edge
//  rst_n     in   1        async reset, active low
//  start     in   1        begin a decode; honoured only in IDLE
//  busy      out  1        high in every state except IDLE
//  in_valid  in   1        input byte valid
//  in_ready  out  1        high only in LOAD
//  in_data   in   8        byte: first OMEGA index bytes, then K cumulative counts
//  h_valid   out  1        h_data/h_sel valid (EMIT)
//  h_ready   in   1        consumer accepts the beat
//  h_data    out  N        hint poly; bit j = coefficient j
//  h_sel     out  KW       poly number 0..K-1; KW = max(1,$clog2(K))
//  done      out  1        1-cycle pulse when decode ends
//  ok        out  1        1 = encoding valid; updated with done, held until next start
// BEHAVIOUR
//  - Reset values: every output 0. FSM to IDLE. Accumulator, counters and buffer cleared.
//  - FSM: IDLE -> LOAD -> {OUTER -> INNER* -> EMIT} x K -> TAIL -> FIN; any check -> ERR.
//  - IDLE: start=1 -> LOAD next cycle; ok cleared. start ignored in all other states.
//  - LOAD: one byte stored per in_valid&in_ready beat.
//    - Beats 0..OMEGA-1 go to the buffer; beats OMEGA..OMEGA+K-1 go to cnt[0..K-1].
//    - Input gaps are allowed. The last beat moves the FSM to OUTER.
//  - OUTER (1 cycle, poly i):
//    - cnt[i] < idx or cnt[i] > OMEGA -> ERR.
//    - Otherwise first = idx. Go to INNER if cnt[i] > idx, else EMIT.
//  - INNER (1 cycle per hint):
//    - b = buf[idx]. b >= N -> ERR.
//    - idx > first and buf[idx-1] >= b -> ERR.
//    - Otherwise acc[b] = 1 and idx++. When idx+1 == cnt[i], go to EMIT.
//  - EMIT:
//    - h_valid=1, h_data=acc, h_sel=i. Data stays stable while h_ready=0.
//    - On the handshake: acc cleared, i++. Go to OUTER, or to TAIL if i was K-1.
//  - TAIL: checks buf[j]==0 for j=idx..OMEGA-1, one per cycle.
//    - Any nonzero -> ERR. idx==OMEGA -> FIN directly.
//  - FIN: done=1, ok=1 -> IDLE. ERR: done=1, ok=0 -> IDLE. No h beats after an error.
//  - Polys already emitted before an error stay invalid. Consumer discards all beats when ok=0.
//  - Widths: idx and first are $clog2(OMEGA+1) bits. cnt and buffer are 8-bit; compares unsigned.
//  - Latency (h_ready=1, no input gaps): 1 + (OMEGA+K) + 2K + hints + (OMEGA-idx_final) + 1.
//  - rst_n low in any state: immediate return to reset values. Partial data is discarded.
// CONFIGURATION
//  HINT_UNPACK_ERR_CODE_EN
//  - Defined: extra port err_code out 3 (hbu_err_t). Set with done, held until next start.
//    Values: NONE=0, COUNT=1, ORDER=2, RANGE=3, TAIL=4.
//  - Undefined: no port, and no error-cause register is synthesised.
// STRUCTURE
//  - hbu_pkg: hbu_state_t; hbu_err_t; HBU_BYTE_W=8.
//  - hbu_pkg: function idx_w(omega) returning $clog2(omega+1).
//  - Sub-module hbu_byte_buf: OMEGA x 8 register file.
//    Write pointer plus two async read ports (idx, idx-1). Shared by INNER and TAIL.
// TESTING (K=8, OMEGA=75, N=256 unless noted)
//  1. All 83 bytes zero, h_ready=1:
//     8 beats with h_data=0, h_sel 0..7. done, ok=1 at cycle 1+83+16+75+1=176 after start.
//  2. buf={3,17,255,0...}, cnt={3,3,3,3,3,3,3,3}:
//     beat 0 has bits 3, 17, 255 set; beats 1..7 zero; ok=1.
//  3. buf={5,5,...}, cnt[0]=2: ERR (ORDER), ok=0, no h_valid. Variant cnt[0]=76: ERR (COUNT).
//  4. cnt={4,2,...}: poly 0 emitted, then ERR (COUNT). N=200 with buf[0]=201: ERR (RANGE).
//  5. cnt all 1, buf={0,9,0...}: 8 beats, then ERR (TAIL) with ok=0.
//  6. Stress and reset:
//     - h_ready low 10 cycles in EMIT: h_data/h_sel stable.
//     - Random in_valid gaps in LOAD: result identical to test 2.
//     - rst_n low mid-INNER: all outputs 0; the next start decodes test 2 correctly.

Source files
------------

// File: rtl/hbu_pkg.sv
// Shared types and helpers for the streaming ML-DSA hint-bit unpacker.
//   hbu_state_t : decoder FSM states
//   hbu_err_t   : error cause reported on err_code (optional port)
//   HBU_BYTE_W  : width of every stream byte, count and buffer entry
//   idx_w()     : width of a hint index able to hold 0..omega
package hbu_pkg;

    localparam int HBU_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_OUTER = 3'd2,
        ST_INNER = 3'd3,
        ST_EMIT  = 3'd4,
        ST_TAIL  = 3'd5,
        ST_FIN   = 3'd6,
        ST_ERR   = 3'd7
    } hbu_state_t;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_COUNT = 3'd1,
        ERR_ORDER = 3'd2,
        ERR_RANGE = 3'd3,
        ERR_TAIL  = 3'd4
    } hbu_err_t;

    function automatic int idx_w(input int omega);
        return $clog2(omega + 1);
    endfunction

endpackage

// File: rtl/hbu_byte_buf.sv
// OMEGA x 8 register file holding the hint index bytes of one encoding.
// Writes are sequential through an internal pointer; two asynchronous read
// ports return buf[i_addr_a] and buf[i_addr_b]. An address outside 0..OMEGA-1
// reads as zero, which keeps the idx-1 port harmless when idx is 0.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears pointer and data)
//   i_clr             rewind write pointer to entry 0
//   i_we, i_wdata     write i_wdata at the pointer, then advance it
//   i_addr_a/b        read addresses
//   o_rdata_a/b       read data
module hbu_byte_buf
    import hbu_pkg::*;
#(
    parameter int OMEGA = 75,
    parameter int IW    = idx_w(75)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic [HBU_BYTE_W-1:0] i_wdata,
    input  logic [IW-1:0]         i_addr_a,
    input  logic [IW-1:0]         i_addr_b,
    output logic [HBU_BYTE_W-1:0] o_rdata_a,
    output logic [HBU_BYTE_W-1:0] o_rdata_b
);

    logic [IW-1:0]         r_wptr;
    logic [HBU_BYTE_W-1:0] r_mem [OMEGA];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            for (int j = 0; j < OMEGA; j++) begin
                r_mem[j] <= '0;
            end
        end else if (i_clr) begin
            r_wptr <= '0;
        end else if (i_we) begin
            for (int j = 0; j < OMEGA; j++) begin
                if (r_wptr == IW'(j)) begin
                    r_mem[j] <= i_wdata;
                end
            end
            r_wptr <= r_wptr + IW'(1);
        end
    end

    always_comb begin
        o_rdata_a = '0;
        o_rdata_b = '0;
        for (int j = 0; j < OMEGA; j++) begin
            if (i_addr_a == IW'(j)) begin
                o_rdata_a = r_mem[j];
            end
            if (i_addr_b == IW'(j)) begin
                o_rdata_b = r_mem[j];
            end
        end
    end

endmodule

// File: rtl/hint_bit_unpack_stream.sv
// Streaming ML-DSA HintBitUnpack for the signature verify path.
// Consumes OMEGA index bytes followed by K cumulative counts, rebuilds K hint
// polynomials of N bits and streams them out one per beat, then reports
// done/ok. Every malformed encoding (count out of order or above OMEGA,
// indices not strictly increasing inside a poly, index >= N, nonzero padding)
// ends the decode with ok=0; beats already emitted must then be discarded.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and once h_valid is raised
// h_data/h_sel stay unchanged until the transfer.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start            begin a decode (IDLE only)
//   busy             high whenever not IDLE
//   in_valid/ready   byte stream in (ready only in LOAD), in_data the byte
//   h_valid/ready    hint poly stream out, h_data bit j = coefficient j,
//                    h_sel the poly number
//   done             one-cycle end-of-decode pulse
//   ok               encoding valid; changes with done, held until next start
//   err_code         error cause, only with HINT_UNPACK_ERR_CODE_EN defined
// Build option: define HINT_UNPACK_ERR_CODE_EN to add err_code.
module hint_bit_unpack_stream
    import hbu_pkg::*;
#(
    parameter int K     = 8,
    parameter int OMEGA = 75,
    parameter int N     = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              busy,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [HBU_BYTE_W-1:0]             in_data,
    output logic                              h_valid,
    input  logic                              h_ready,
    output logic [N-1:0]                      h_data,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] h_sel,
    output logic                              done,
    output logic                              ok
`ifdef HINT_UNPACK_ERR_CODE_EN
    ,
    output logic [2:0]                        err_code
`endif
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int IW = idx_w(OMEGA);
    // Common width for comparing 8-bit counts against hint indices.
    localparam int CW = (IW > HBU_BYTE_W) ? IW : HBU_BYTE_W;
    localparam int LW = $clog2(OMEGA + K + 1);

    hbu_state_t            r_state, w_state_nxt;
    logic [LW-1:0]         r_ld, w_ld_nxt;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic [IW-1:0]         r_first, w_first_nxt;
    logic [KW-1:0]         r_sel, w_sel_nxt;
    logic [N-1:0]          r_acc, w_acc_nxt;
    logic                  r_ok, w_ok_nxt;
    logic [HBU_BYTE_W-1:0] r_cnt [K];

    hbu_err_t              w_err_cause;
    logic                  w_beat;
    logic                  w_buf_we;
    logic                  w_buf_clr;
    logic [HBU_BYTE_W-1:0] w_cnt_i;
    logic [HBU_BYTE_W-1:0] w_b;
    logic [HBU_BYTE_W-1:0] w_b_prev;
    logic [IW-1:0]         w_idx_m1;

    assign w_beat   = in_valid && (r_state == ST_LOAD);
    assign w_idx_m1 = r_idx - IW'(1);

    hbu_byte_buf #(
        .OMEGA (OMEGA),
        .IW    (IW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_buf_clr),
        .i_we      (w_buf_we),
        .i_wdata   (in_data),
        .i_addr_a  (r_idx),
        .i_addr_b  (w_idx_m1),
        .o_rdata_a (w_b),
        .o_rdata_b (w_b_prev)
    );

    // Cumulative count of the poly currently being decoded.
    always_comb begin
        w_cnt_i = '0;
        for (int k = 0; k < K; k++) begin
            if (r_sel == KW'(k)) begin
                w_cnt_i = r_cnt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ld    <= '0;
            r_idx   <= '0;
            r_first <= '0;
            r_sel   <= '0;
            r_acc   <= '0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ld    <= w_ld_nxt;
            r_idx   <= w_idx_nxt;
            r_first <= w_first_nxt;
            r_sel   <= w_sel_nxt;
            r_acc   <= w_acc_nxt;
            r_ok    <= w_ok_nxt;
        end
    end

    // Counts arrive after the OMEGA index bytes, in poly order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < K; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < K; k++) begin
                if (w_beat && (r_ld == LW'(OMEGA + k))) begin
                    r_cnt[k] <= in_data;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_nxt    = r_ld;
        w_idx_nxt   = r_idx;
        w_first_nxt = r_first;
        w_sel_nxt   = r_sel;
        w_acc_nxt   = r_acc;
        w_ok_nxt    = r_ok;
        w_err_cause = ERR_NONE;
        w_buf_we    = 1'b0;
        w_buf_clr   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_ok_nxt    = 1'b0;
                    w_ld_nxt    = '0;
                    w_idx_nxt   = '0;
                    w_first_nxt = '0;
                    w_sel_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_buf_clr   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_beat) begin
                    w_ld_nxt = r_ld + LW'(1);
                    w_buf_we = (r_ld < LW'(OMEGA));
                    if (r_ld == LW'(OMEGA + K - 1)) begin
                        w_state_nxt = ST_OUTER;
                    end
                end
            end
            ST_OUTER: begin
                if ((CW'(w_cnt_i) < CW'(r_idx)) || (CW'(w_cnt_i) > CW'(OMEGA))) begin
                    w_err_cause = ERR_COUNT;
                end else begin
                    w_first_nxt = r_idx;
                    w_state_nxt = (CW'(w_cnt_i) > CW'(r_idx)) ? ST_INNER : ST_EMIT;
                end
            end
            ST_INNER: begin
                if (32'(w_b) >= 32'(N)) begin
                    w_err_cause = ERR_RANGE;
                end else if ((r_idx > r_first) && (w_b_prev >= w_b)) begin
                    w_err_cause = ERR_ORDER;
                end else begin
                    w_acc_nxt = r_acc | (N'(1) << w_b);
                    w_idx_nxt = r_idx + IW'(1);
                    if ((CW'(r_idx) + CW'(1)) == CW'(w_cnt_i)) begin
                        w_state_nxt = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (h_ready) begin
                    w_acc_nxt = '0;
                    w_sel_nxt = r_sel + KW'(1);
                    if (r_sel == KW'(K - 1)) begin
                        // No padding left to check when every slot was a hint.
                        if (r_idx == IW'(OMEGA)) begin
                            w_state_nxt = ST_FIN;
                            w_ok_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = ST_TAIL;
                        end
                    end else begin
                        w_state_nxt = ST_OUTER;
                    end
                end
            end
            ST_TAIL: begin
                if (w_b != '0) begin
                    w_err_cause = ERR_TAIL;
                end else begin
                    w_idx_nxt = r_idx + IW'(1);
                    if ((r_idx + IW'(1)) == IW'(OMEGA)) begin
                        w_state_nxt = ST_FIN;
                        w_ok_nxt    = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_err_cause != ERR_NONE) begin
            w_state_nxt = ST_ERR;
            w_ok_nxt    = 1'b0;
        end
    end

`ifdef HINT_UNPACK_ERR_CODE_EN
    hbu_err_t r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= ERR_NONE;
        end else if ((r_state == ST_IDLE) && start) begin
            r_err <= ERR_NONE;
        end else if (w_err_cause != ERR_NONE) begin
            r_err <= w_err_cause;
        end
    end

    assign err_code = r_err;
`endif

    assign busy     = (r_state != ST_IDLE);
    assign in_ready = (r_state == ST_LOAD);
    assign h_valid  = (r_state == ST_EMIT);
    assign h_data   = r_acc;
    assign h_sel    = r_sel;
    assign done     = (r_state == ST_FIN) || (r_state == ST_ERR);
    assign ok       = r_ok;

endmodule
